// File: rtl/tinyjambu_state_update_d1.sv
// First-order masked TinyJAMBU-128 state update controller.
// Holds the two-share 128-bit NLFSR state, feeds bits [116:70] of each share
// to the external HPC2 NAND core and shifts in 32 feedback bits per iteration.
module tinyjambu_state_update_d1 #(
  parameter int unsigned NAND_LATENCY = 2,
  parameter int unsigned ITER_SHORT   = 20,
  parameter int unsigned ITER_LONG    = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [127:0] state_in_s0,
  input  logic [127:0] state_in_s1,
  input  logic [127:0] key_s0,
  input  logic [127:0] key_s1,
  input  logic         start,
  input  logic         long_perm,
  output logic [46:0]  nand_x_s0,
  output logic [46:0]  nand_x_s1,
  input  logic [31:0]  nand_y_s0,
  input  logic [31:0]  nand_y_s1,
  output logic         fresh_req,
  output logic         busy,
  output logic         done,
  output logic [127:0] state_out_s0,
  output logic [127:0] state_out_s1
);

  localparam int unsigned PH_W = (NAND_LATENCY < 1) ? 1 : $clog2(NAND_LATENCY + 1);
  localparam int unsigned IT_W = $clog2(ITER_LONG + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e            fsm_q, fsm_d;
  logic [127:0]      s0_q, s0_d;
  logic [127:0]      s1_q, s1_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [IT_W-1:0]   iter_q, iter_d;
  logic [IT_W-1:0]   limit_q, limit_d;
  logic              done_q, done_d;

  logic              upd;
  logic              last;
  logic [6:0]        kidx;
  logic [31:0]       kw0, kw1;
  logic [31:0]       fb0, fb1;

  // Update strobe, last-iteration detect and per-share feedback words
  always_comb begin
    upd  = (fsm_q == RUN) && (phase_q == PH_W'(NAND_LATENCY));
    last = (iter_q == (limit_q - IT_W'(1)));
    kidx = {iter_q[1:0], 5'd0};
    kw0  = key_s0[kidx +: 32];
    kw1  = key_s1[kidx +: 32];
    // y shares already carry the NAND complement; shares stay separate
    fb0  = s0_q[31:0] ^ s0_q[78:47] ^ nand_y_s0 ^ s0_q[122:91] ^ kw0;
    fb1  = s1_q[31:0] ^ s1_q[78:47] ^ nand_y_s1 ^ s1_q[122:91] ^ kw1;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm_q <= IDLE;
    else     fsm_q <= fsm_d;
  end

  // FSM next-state logic
  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      IDLE: if (start && !load) fsm_d = RUN;
      RUN:  if (upd && last)    fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy      = (fsm_q == RUN);
    fresh_req = (fsm_q == RUN) && (phase_q == '0);
    done      = done_q;
  end

  // Datapath next values: load, run setup, phase/iteration stepping, shift
  always_comb begin
    s0_d    = s0_q;
    s1_d    = s1_q;
    phase_d = phase_q;
    iter_d  = iter_q;
    limit_d = limit_q;
    done_d  = 1'b0;
    if (fsm_q == IDLE) begin
      if (load) begin
        s0_d = state_in_s0;
        s1_d = state_in_s1;
      end else if (start) begin
        limit_d = long_perm ? IT_W'(ITER_LONG) : IT_W'(ITER_SHORT);
        phase_d = '0;
        iter_d  = '0;
      end
    end else if (upd) begin
      s0_d    = {fb0, s0_q[127:32]};
      s1_d    = {fb1, s1_q[127:32]};
      phase_d = '0;
      iter_d  = iter_q + IT_W'(1);
      done_d  = last;
    end else begin
      phase_d = phase_q + PH_W'(1);
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q    <= '0;
      s1_q    <= '0;
      phase_q <= '0;
      iter_q  <= '0;
      limit_q <= '0;
      done_q  <= 1'b0;
    end else begin
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      phase_q <= phase_d;
      iter_q  <= iter_d;
      limit_q <= limit_d;
      done_q  <= done_d;
    end
  end

  // Register-driven share outputs
  always_comb begin
    nand_x_s0    = s0_q[116:70];
    nand_x_s1    = s1_q[116:70];
    state_out_s0 = s0_q;
    state_out_s1 = s1_q;
  end

endmodule

// File: tb/tb_tinyjambu_state_update_d1.sv
// Scoreboard bench for tinyjambu_state_update_d1 with a bit-serial
// unmasked TinyJAMBU-128 reference and a masked combinational NAND core.
module tb_tinyjambu_state_update_d1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load = 1'b0;
  logic [127:0] state_in_s0 = '0;
  logic [127:0] state_in_s1 = '0;
  logic [127:0] key_s0 = '0;
  logic [127:0] key_s1 = '0;
  logic         start = 1'b0;
  logic         long_perm = 1'b0;
  logic [46:0]  nand_x_s0, nand_x_s1;
  logic [31:0]  nand_y_s0 = '0;
  logic [31:0]  nand_y_s1 = '0;
  logic         fresh_req, busy, done;
  logic [127:0] state_out_s0, state_out_s1;

  tinyjambu_state_update_d1 #(
    .NAND_LATENCY(2),
    .ITER_SHORT(20),
    .ITER_LONG(32)
  ) dut (
    .clk(clk), .rst(rst), .load(load),
    .state_in_s0(state_in_s0), .state_in_s1(state_in_s1),
    .key_s0(key_s0), .key_s1(key_s1),
    .start(start), .long_perm(long_perm),
    .nand_x_s0(nand_x_s0), .nand_x_s1(nand_x_s1),
    .nand_y_s0(nand_y_s0), .nand_y_s1(nand_y_s1),
    .fresh_req(fresh_req), .busy(busy), .done(done),
    .state_out_s0(state_out_s0), .state_out_s1(state_out_s1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0]    st;
    longint unsigned done_cyc;
    int unsigned     iters;
  } exp_t;

  exp_t            sb[$];
  exp_t            me;
  longint unsigned cyc = 0;
  int unsigned     n_tests = 0;
  int unsigned     n_fail = 0;
  int unsigned     busy_cnt = 0;
  int unsigned     fresh_cnt = 0;
  logic            prev_done = 1'b0;
  logic [46:0]     xa;
  logic [31:0]     m;

  always @(posedge clk) cyc <= cyc + 1;

  // Masked NAND core model: y0 ^ y1 = ~(a & b) with a fresh mask every cycle
  always @(negedge clk) begin
    xa = nand_x_s0 ^ nand_x_s1;
    m  = $urandom;
    nand_y_s0 = m;
    nand_y_s1 = m ^ ~(xa[31:0] & xa[46:15]);
  end

  // Bit-serial TinyJAMBU-128 permutation, one feedback bit per step
  function automatic logic [127:0] ref_perm(input logic [127:0] s_in,
                                             input logic [127:0] k,
                                             input int unsigned rounds);
    logic [127:0] s;
    logic         fb;
    s = s_in;
    for (int unsigned i = 0; i < rounds * 32; i++) begin
      fb = s[0] ^ s[47] ^ ~(s[70] & s[85]) ^ s[91] ^ k[i % 128];
      s  = {fb, s[127:1]};
    end
    return s;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_ne(input string name, input logic [127:0] act, input logic [127:0] forbidden);
    n_tests++;
    if (act === forbidden) begin
      n_fail++;
      $display("FAIL %s: share %h equals unmasked value", name, act);
    end
  endtask

  // Monitor: pops the scoreboard whenever done is presented
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt  = 0;
      fresh_cnt = 0;
      prev_done = 1'b0;
    end else begin
      if (busy)      busy_cnt++;
      if (fresh_req) fresh_cnt++;
      if (done) begin
        chk("done_one_cycle", {127'd0, prev_done}, 128'd0);
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no pending run");
        end else begin
          me = sb.pop_front();
          chk("result", state_out_s0 ^ state_out_s1, me.st);
          chk_ne("share0_alone", state_out_s0, me.st);
          chk_ne("share1_alone", state_out_s1, me.st);
          chk("done_cycle", 128'(cyc), 128'(me.done_cyc));
          chk("busy_cycles", 128'(busy_cnt), 128'(3 * me.iters));
          chk("fresh_pulses", 128'(fresh_cnt), 128'(me.iters));
        end
        busy_cnt  = 0;
        fresh_cnt = 0;
      end
      prev_done = done;
    end
  end

  task automatic do_load(input logic [127:0] s0, input logic [127:0] s1);
    @(negedge clk);
    load = 1'b1;
    state_in_s0 = s0;
    state_in_s1 = s1;
    @(negedge clk);
    load = 1'b0;
    chk("load_s0", state_out_s0, s0);
    chk("load_s1", state_out_s1, s1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: got %0d pending runs expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_perm(input logic [127:0] s0, input logic [127:0] s1,
                          input logic [127:0] k0, input logic [127:0] k1,
                          input bit lng, input int unsigned n_upd,
                          input bit first_const, input bit junk);
    logic [127:0] su, ku;
    int unsigned  n;
    exp_t         e;
    do_load(s0, s1);
    su = s0 ^ s1;
    ku = k0 ^ k1;
    n  = lng ? 32 : 20;
    key_s0 = k0;
    key_s1 = k1;
    start = 1'b1;
    long_perm = lng;
    e.st = ref_perm(su, ku, n);
    e.done_cyc = cyc + 1 + 3 * n;
    e.iters = n;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    long_perm = 1'($urandom);
    for (int unsigned u = 0; u < n_upd; u++) begin
      repeat (3) @(negedge clk);
      chk("per_update", state_out_s0 ^ state_out_s1, ref_perm(su, ku, u + 1));
      if (first_const && u == 0)
        chk("upd0_const", state_out_s0 ^ state_out_s1, {32'hFFFF_FFFF, 96'h0});
    end
    if (junk) begin
      repeat (5) @(negedge clk);
      load = 1'b1;
      start = 1'b1;
      state_in_s0 = {$urandom, $urandom, $urandom, $urandom};
      state_in_s1 = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      load = 1'b0;
      start = 1'b0;
      repeat (7) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done();
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] r, kr, a, b, kc;

    // Reset state
    #1;
    chk("rst_state_s0", state_out_s0, '0);
    chk("rst_state_s1", state_out_s1, '0);
    chk("rst_nand_x", {34'd0, nand_x_s0, nand_x_s1}, '0);
    chk("rst_ctrl", {125'd0, busy, done, fresh_req}, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Zero state, zero key, unmasked
    run_perm('0, '0, '0, '0, 1'b0, 2, 1'b1, 1'b0);

    // Zero state with random masks on state and key
    r  = rnd128();
    kr = rnd128();
    run_perm(r, r, kr, kr, 1'b0, 2, 1'b1, 1'b0);

    // Key word cycling 1, 2, 4, 8, 1 on a zero state
    kc = {32'h8, 32'h4, 32'h2, 32'h1};
    kr = rnd128();
    r  = rnd128();
    run_perm(r, r, kc ^ kr, kr, 1'b0, 5, 1'b0, 1'b0);

    // Random full permutations, both lengths
    for (int t = 0; t < 6; t++) begin
      a  = rnd128();
      b  = rnd128();
      r  = rnd128();
      kr = rnd128();
      run_perm(a, b, r, kr, (t % 2) == 1, 0, 1'b0, 1'b0);
    end

    // load and start together in IDLE: load wins, no run
    a = rnd128();
    b = rnd128();
    @(negedge clk);
    load = 1'b1;
    start = 1'b1;
    state_in_s0 = a;
    state_in_s1 = b;
    @(negedge clk);
    load = 1'b0;
    start = 1'b0;
    chk("ls_state_s0", state_out_s0, a);
    chk("ls_state_s1", state_out_s1, b);
    chk("ls_nand_x", {34'd0, nand_x_s0, nand_x_s1}, {34'd0, a[116:70], b[116:70]});
    chk("ls_busy", {127'd0, busy}, '0);
    @(negedge clk);
    chk("ls_busy_next", {127'd0, busy}, '0);

    // start/load pulsed during RUN have no effect
    run_perm(rnd128(), rnd128(), rnd128(), rnd128(), 1'b1, 1, 1'b0, 1'b1);

    // Reset in cycle 30 of a P1024 run
    do_load(rnd128(), rnd128());
    key_s0 = rnd128();
    key_s1 = rnd128();
    start = 1'b1;
    long_perm = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    chk("pre_rst_busy", {127'd0, busy}, 128'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_s0", state_out_s0, '0);
    chk("mid_rst_s1", state_out_s1, '0);
    chk("mid_rst_nand_x", {34'd0, nand_x_s0, nand_x_s1}, '0);
    chk("mid_rst_ctrl", {125'd0, busy, done, fresh_req}, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    run_perm(rnd128(), rnd128(), rnd128(), rnd128(), 1'b0, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
